// File: rtl/ic_req_flit_fifo.sv
// Store-and-forward flit buffer between the ICache request upload FSM and the ring arbiter.
// A packet is offered downstream only once all of its flits are buffered.
module ic_req_flit_fifo #(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int PKT_FLITS = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   ic_flit_in,
    input  logic          v_ic_flit_in,
    output logic          req_fifo_rdy,
    output logic [15:0]   flit_out,
    output logic          v_flit_out,
    output logic          flit_head,
    output logic          flit_tail,
    input  logic          flit_ack,
    output logic [AW:0]   flit_count
);

    localparam int FW = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
    localparam logic [FW-1:0] LAST = FW'(PKT_FLITS - 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   pkt_cnt;
    logic [FW-1:0] wr_flit_cnt;
    logic [FW-1:0] rd_flit_cnt;

    logic wr_en;
    logic rd_en;
    logic wr_last;
    logic rd_last;
    logic pkt_inc;
    logic pkt_dec;

    // rdy must not depend on v_ic_flit_in: upstream valid is gated by it
    assign req_fifo_rdy = !rst && (count < FULL);
    assign v_flit_out   = (pkt_cnt != '0);
    assign flit_out     = mem[rd_ptr];
    assign flit_head    = v_flit_out && (rd_flit_cnt == '0);
    assign flit_tail    = v_flit_out && (rd_flit_cnt == LAST);
    assign flit_count   = count;

    assign wr_en   = v_ic_flit_in && req_fifo_rdy;
    assign rd_en   = flit_ack && v_flit_out;
    assign wr_last = (wr_flit_cnt == LAST);
    assign rd_last = (rd_flit_cnt == LAST);
    assign pkt_inc = wr_en && wr_last;
    assign pkt_dec = rd_en && rd_last;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= ic_flit_in;
        end
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pkt_cnt     <= '0;
            wr_flit_cnt <= '0;
            rd_flit_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr      <= wr_ptr + AW'(1);
                wr_flit_cnt <= wr_last ? '0 : wr_flit_cnt + FW'(1);
            end
            if (rd_en) begin
                rd_ptr      <= rd_ptr + AW'(1);
                rd_flit_cnt <= rd_last ? '0 : rd_flit_cnt + FW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_cnt <= pkt_cnt + (AW + 1)'(1);
                2'b01:   pkt_cnt <= pkt_cnt - (AW + 1)'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ic_req_flit_fifo.sv
// Directed bench for ic_req_flit_fifo: vector table plus hand-written
// sequences for full, wrap streaming and same-cycle packet hand-over.
module tb_ic_req_flit_fifo;

    logic        clk;
    logic        rst;
    logic [15:0] ic_flit_in;
    logic        v_ic_flit_in;
    logic        req_fifo_rdy;
    logic [15:0] flit_out;
    logic        v_flit_out;
    logic        flit_head;
    logic        flit_tail;
    logic        flit_ack;
    logic [3:0]  flit_count;

    int n_chk  = 0;
    int n_pass = 0;

    ic_req_flit_fifo #(.DEPTH(8), .AW(3), .PKT_FLITS(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .ic_flit_in   (ic_flit_in),
        .v_ic_flit_in (v_ic_flit_in),
        .req_fifo_rdy (req_fifo_rdy),
        .flit_out     (flit_out),
        .v_flit_out   (v_flit_out),
        .flit_head    (flit_head),
        .flit_tail    (flit_tail),
        .flit_ack     (flit_ack),
        .flit_count   (flit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        v;
        logic [15:0] d;
        logic        a;
        logic        e_rdy;
        logic        e_vo;
        logic        e_hd;
        logic        e_tl;
        logic [15:0] e_do;
        logic        cd;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h",
                      name, idx, act, exp);
    endtask

    // apply inputs for one edge, then sample 1 time unit after it
    task automatic step(input logic r, input logic v,
                        input logic [15:0] d, input logic a);
        rst          = r;
        v_ic_flit_in = v;
        ic_flit_in   = d;
        flit_ack     = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v_ic_flit_in = 1'b0;
        flit_ack     = 1'b0;
        rst          = 1'b0;
    endtask

    int j;
    logic seen_dead;

    initial begin
        rst          = 1'b1;
        v_ic_flit_in = 1'b0;
        ic_flit_in   = '0;
        flit_ack     = 1'b0;

        //          r  v  d        a  rdy vo hd tl dout     cd cnt
        tbl[0]  = '{1, 0, 16'h0,    0, 0,  0, 0, 0, 16'h0,    0, 0};
        tbl[1]  = '{0, 0, 16'h0,    0, 1,  0, 0, 0, 16'h0,    0, 0};
        tbl[2]  = '{0, 1, 16'h1111, 0, 1,  0, 0, 0, 16'h0,    0, 1};
        tbl[3]  = '{0, 1, 16'h2222, 0, 1,  0, 0, 0, 16'h0,    0, 2};
        tbl[4]  = '{0, 1, 16'h3333, 0, 1,  1, 1, 0, 16'h1111, 1, 3};
        tbl[5]  = '{0, 0, 16'h0,    1, 1,  1, 0, 0, 16'h2222, 1, 2};
        tbl[6]  = '{0, 0, 16'h0,    1, 1,  1, 0, 1, 16'h3333, 1, 1};
        tbl[7]  = '{0, 0, 16'h0,    1, 1,  0, 0, 0, 16'h0,    0, 0};
        tbl[8]  = '{0, 0, 16'h0,    1, 1,  0, 0, 0, 16'h0,    0, 0};
        tbl[9]  = '{0, 1, 16'h5555, 0, 1,  0, 0, 0, 16'h0,    0, 1};
        tbl[10] = '{0, 1, 16'h6666, 0, 1,  0, 0, 0, 16'h0,    0, 2};
        tbl[11] = '{1, 1, 16'h7777, 0, 0,  0, 0, 0, 16'h0,    0, 0};
        tbl[12] = '{0, 1, 16'h000A, 0, 1,  0, 0, 0, 16'h0,    0, 1};
        tbl[13] = '{0, 1, 16'h000B, 0, 1,  0, 0, 0, 16'h0,    0, 2};
        tbl[14] = '{0, 1, 16'h000C, 0, 1,  1, 1, 0, 16'h000A, 1, 3};
        tbl[15] = '{0, 0, 16'h0,    1, 1,  1, 0, 0, 16'h000B, 1, 2};
        tbl[16] = '{0, 0, 16'h0,    1, 1,  1, 0, 1, 16'h000C, 1, 1};
        tbl[17] = '{0, 0, 16'h0,    1, 1,  0, 0, 0, 16'h0,    0, 0};

        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].a);
            chk("rdy",   i, 32'(req_fifo_rdy), 32'(tbl[i].e_rdy));
            chk("v_out", i, 32'(v_flit_out),   32'(tbl[i].e_vo));
            chk("head",  i, 32'(flit_head),    32'(tbl[i].e_hd));
            chk("tail",  i, 32'(flit_tail),    32'(tbl[i].e_tl));
            chk("count", i, 32'(flit_count),   32'(tbl[i].e_cnt));
            if (tbl[i].cd) chk("dout", i, 32'(flit_out), 32'(tbl[i].e_do));
        end

        // full: 8 flits, 9th ignored, one pop re-raises rdy
        step(1, 0, 16'h0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 16'h8000 + 16'(i), 0);
        chk("full_rdy", 0, 32'(req_fifo_rdy), 32'd0);
        chk("full_cnt", 0, 32'(flit_count),   32'd8);
        step(0, 1, 16'hDEAD, 0);
        chk("full_rdy", 1, 32'(req_fifo_rdy), 32'd0);
        chk("full_cnt", 1, 32'(flit_count),   32'd8);
        chk("full_out", 0, 32'(flit_out),     32'h8000);
        step(0, 1, 16'hDEAD, 1);
        chk("full_rdy", 2, 32'(req_fifo_rdy), 32'd1);
        chk("full_cnt", 2, 32'(flit_count),   32'd7);
        seen_dead = 1'b0;
        for (int i = 1; i < 6; i++) begin
            chk("full_drain", i, 32'(flit_out), 32'h8000 + 32'(i));
            if (flit_out == 16'hDEAD) seen_dead = 1'b1;
            step(0, 0, 16'h0, 1);
        end
        chk("full_vout", 0, 32'(v_flit_out), 32'd0);
        chk("full_cnt",  3, 32'(flit_count), 32'd2);
        step(0, 1, 16'h8008, 0);
        chk("full_vout", 1, 32'(v_flit_out), 32'd1);
        chk("full_head", 0, 32'(flit_head),  32'd1);
        for (int i = 6; i < 9; i++) begin
            chk("full_tail", i, 32'(flit_out), 32'h8000 + 32'(i));
            if (flit_out == 16'hDEAD) seen_dead = 1'b1;
            step(0, 0, 16'h0, 1);
        end
        chk("no_dead", 0, 32'(seen_dead),   32'd0);
        chk("full_end", 0, 32'(flit_count), 32'd0);

        // streaming 4 packets with continuous ack across pointer wrap
        step(1, 0, 16'h0, 0);
        idle();
        j = 0;
        for (int c = 0; c < 20; c++) begin
            if (v_flit_out) begin
                chk("strm_out",  j, 32'(flit_out),  32'h4000 + 32'(j));
                chk("strm_head", j, 32'(flit_head), 32'((j % 3) == 0));
                chk("strm_tail", j, 32'(flit_tail), 32'((j % 3) == 2));
                j++;
            end
            step(0, c < 12, 16'h4000 + 16'(c), 1);
        end
        chk("strm_num", 0, 32'(j),          32'd12);
        chk("strm_cnt", 0, 32'(flit_count), 32'd0);

        // tail pop coincides with the write completing the next packet
        step(1, 0, 16'h0, 0);
        step(0, 1, 16'h06A0, 0);
        step(0, 1, 16'h06A1, 0);
        step(0, 1, 16'h06A2, 0);
        step(0, 1, 16'h06B0, 0);
        step(0, 1, 16'h06B1, 0);
        step(0, 0, 16'h0, 1);
        step(0, 0, 16'h0, 1);
        chk("ovl_tail", 0, 32'(flit_tail),  32'd1);
        chk("ovl_out",  0, 32'(flit_out),   32'h06A2);
        chk("ovl_cnt",  0, 32'(flit_count), 32'd3);
        step(0, 1, 16'h06B2, 1);
        chk("ovl_vout", 1, 32'(v_flit_out), 32'd1);
        chk("ovl_head", 1, 32'(flit_head),  32'd1);
        chk("ovl_out",  1, 32'(flit_out),   32'h06B0);
        chk("ovl_cnt",  1, 32'(flit_count), 32'd3);
        step(0, 0, 16'h0, 1);
        step(0, 0, 16'h0, 1);
        chk("ovl_out",  2, 32'(flit_out),   32'h06B2);
        chk("ovl_tail", 2, 32'(flit_tail),  32'd1);
        step(0, 0, 16'h0, 1);
        chk("ovl_vout", 3, 32'(v_flit_out), 32'd0);
        chk("ovl_cnt",  3, 32'(flit_count), 32'd0);

        idle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
